// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: 16x oversampled receiver with majority voting,
// parity/framing/overrun flags, CTS-gated transmitter and RTS on a full holding register.
module uart_core_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 CLK_50MHZ,
    input  logic                 RST,
    input  logic                 RX,
    output logic                 TX,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 TRG_WRITE,
    output logic                 TX_BUSY,
    input  logic                 FLOW,
    output logic                 RTS,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 DONE,
    input  logic                 TRG_READ,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W   = $clog2(OVERSAMPLE);
    localparam int CNT_MAX = OVERSAMPLE - 1;
    localparam int SMP_LO  = OVERSAMPLE / 2 - 1;
    localparam int SMP_MID = OVERSAMPLE / 2;
    localparam int SMP_HI  = OVERSAMPLE / 2 + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Odd parity makes the total count of ones (payload + parity bit) odd.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    // ---------------- shared receive tick ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // ---------------- receiver ----------------
    state_t               r_rx_state;
    logic                 r_rx_meta;
    logic                 r_rxs;
    logic                 r_rxs_d;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 r_v_lo;
    logic                 r_v_mid;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_done;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;
    logic                 w_maj;

    // Third vote is the live synchronised sample taken on the SMP_HI tick.
    assign w_maj = maj3(r_v_lo, r_v_mid, r_rxs);

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_rx_state <= ST_IDLE;
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_d    <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_v_lo     <= 1'b1;
            r_v_mid    <= 1'b1;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rx_meta <= RX;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;

            if (TRG_READ) begin
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end

            if (r_rx_state == ST_IDLE) begin
                if (r_rxs_d && !r_rxs) begin
                    r_rx_state <= ST_START;
                    r_rx_cnt   <= '0;
                end
            end else if (w_tick) begin
                if (r_rx_cnt == CNT_W'(SMP_LO))  r_v_lo  <= r_rxs;
                if (r_rx_cnt == CNT_W'(SMP_MID)) r_v_mid <= r_rxs;
                r_rx_cnt <= (r_rx_cnt == CNT_W'(CNT_MAX)) ? '0 : r_rx_cnt + CNT_W'(1);

                case (r_rx_state)
                    ST_START: begin
                        if (r_rx_cnt == CNT_W'(SMP_HI) && w_maj) begin
                            r_rx_state <= ST_IDLE;
                        end else if (r_rx_cnt == CNT_W'(CNT_MAX)) begin
                            r_rx_state <= ST_DATA;
                            r_rx_bit   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (r_rx_cnt == CNT_W'(SMP_HI)) begin
                            r_rx_shift <= {w_maj, r_rx_shift[DATA_BITS-1:1]};
                        end
                        if (r_rx_cnt == CNT_W'(CNT_MAX)) begin
                            if (r_rx_bit == 4'(DATA_BITS - 1)) begin
                                r_rx_state <= (PARITY != 0) ? ST_PAR : ST_STOP;
                            end else begin
                                r_rx_bit <= r_rx_bit + 4'd1;
                            end
                        end
                    end
                    ST_PAR: begin
                        if (r_rx_cnt == CNT_W'(SMP_HI)) r_rx_par <= w_maj;
                        if (r_rx_cnt == CNT_W'(CNT_MAX)) r_rx_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Frame end overrides a same-cycle TRG_READ clear.
                        if (r_rx_cnt == CNT_W'(SMP_HI)) begin
                            r_data_out <= r_rx_shift;
                            r_done     <= 1'b1;
                            r_perr     <= (PARITY != 0) && (r_rx_par != calc_parity(r_rx_shift));
                            r_ferr     <= ~w_maj;
                            r_overrun  <= r_overrun | r_done;
                            r_rx_state <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- transmitter ----------------
    state_t               r_tx_state;
    logic                 r_tx;
    logic                 r_tx_busy;
    logic [DIV_W-1:0]     r_tx_div;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [1:0]           r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_tx_parbit;
    logic                 w_tx_tick;

    assign w_tx_tick = (r_tx_div == DIV_W'(DIV - 1));

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_tx_state  <= ST_IDLE;
            r_tx        <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_div    <= '0;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_stop   <= '0;
            r_tx_data   <= '0;
            r_tx_parbit <= 1'b0;
        end else if (r_tx_state == ST_IDLE) begin
            r_tx <= 1'b1;
            if (TRG_WRITE && !FLOW && !r_tx_busy) begin
                r_tx_data   <= DATA_IN;
                r_tx_parbit <= calc_parity(DATA_IN);
                r_tx_busy   <= 1'b1;
                r_tx        <= 1'b0;
                r_tx_state  <= ST_START;
                r_tx_div    <= '0;
                r_tx_cnt    <= '0;
            end
        end else begin
            r_tx_div <= w_tx_tick ? '0 : r_tx_div + DIV_W'(1);
            if (w_tx_tick) begin
                r_tx_cnt <= (r_tx_cnt == CNT_W'(CNT_MAX)) ? '0 : r_tx_cnt + CNT_W'(1);
                // Bit boundary: present the next line level on the same edge.
                if (r_tx_cnt == CNT_W'(CNT_MAX)) begin
                    case (r_tx_state)
                        ST_START: begin
                            r_tx_state <= ST_DATA;
                            r_tx_bit   <= '0;
                            r_tx       <= r_tx_data[0];
                        end
                        ST_DATA: begin
                            if (r_tx_bit == 4'(DATA_BITS - 1)) begin
                                r_tx_stop <= '0;
                                if (PARITY != 0) begin
                                    r_tx_state <= ST_PAR;
                                    r_tx       <= r_tx_parbit;
                                end else begin
                                    r_tx_state <= ST_STOP;
                                    r_tx       <= 1'b1;
                                end
                            end else begin
                                r_tx_bit  <= r_tx_bit + 4'd1;
                                r_tx      <= r_tx_data[1];
                                r_tx_data <= r_tx_data >> 1;
                            end
                        end
                        ST_PAR: begin
                            r_tx_state <= ST_STOP;
                            r_tx       <= 1'b1;
                        end
                        ST_STOP: begin
                            if (r_tx_stop == 2'(STOP_BITS - 1)) begin
                                r_tx_state <= ST_IDLE;
                                r_tx_busy  <= 1'b0;
                            end else begin
                                r_tx_stop <= r_tx_stop + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign TX         = r_tx;
    assign TX_BUSY    = r_tx_busy;
    assign RTS        = r_done;
    assign DATA_OUT   = r_data_out;
    assign DONE       = r_done;
    assign PARITY_ERR = r_perr;
    assign FRAME_ERR  = r_ferr;
    assign OVERRUN    = r_overrun;

endmodule
